// File: rtl/bus_pkg.sv
// Definitions shared by both sides of the wide bus FIFO: default geometry,
// lane-index width helper and the drain state encoding.
package bus_pkg;

    localparam int unsigned BUS_WIDTH    = 32;
    localparam int unsigned BUS_IN_DEPTH = 6;

    typedef enum logic {
        StEmpty,
        StStream
    } bus_state_e;

    // A single-lane entry still needs a 1-bit lane index.
    function automatic int unsigned lane_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bus_fifo_unpacker.sv
// Read-side drain for the wide bus FIFO: pops one IN_DEPTH*WIDTH entry from a
// show-ahead FIFO and serialises it lane 0 first as a WIDTH-bit valid/ready stream.
module bus_fifo_unpacker
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH    = BUS_WIDTH,
    parameter int unsigned IN_DEPTH = BUS_IN_DEPTH,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned LANE_W  = lane_w(IN_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      fifo_empty,
    input  logic [IN_DEPTH*WIDTH-1:0] fifo_rd_data,
    output logic                      fifo_rd_en,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [LANE_W-1:0]         out_lane,
    output logic                      out_last,
    output logic                      busy,
    output logic [CNT_W-1:0]          beat_cnt
);

    localparam logic [LANE_W-1:0] LastLane = LANE_W'(IN_DEPTH - 1);

    bus_state_e                state_q, state_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [IN_DEPTH*WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;

    logic hold_valid;
    logic hs;
    logic done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StEmpty;
            lane_q     <= '0;
            hold_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            hold_q     <= hold_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        hold_valid = (state_q == StStream);
        // Flush masks valid in the same cycle so no beat can slip out during an abort.
        out_valid  = hold_valid & ~flush;
        out_lane   = lane_q;
        out_last   = (lane_q == LastLane);
        out_data   = hold_q[int'(lane_q) * WIDTH +: WIDTH];
        busy       = hold_valid;
        beat_cnt   = beat_cnt_q;
        hs         = out_valid & out_ready;
        done       = hs & out_last;
        fifo_rd_en = ~flush & ~fifo_empty & (~hold_valid | done);
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        hold_d     = hold_q;
        beat_cnt_d = hs ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;
        if (flush) begin
            state_d = StEmpty;
            lane_d  = '0;
        end else if (fifo_rd_en) begin
            // Covers both the first load and a bubble-free reload on the last beat.
            state_d = StStream;
            hold_d  = fifo_rd_data;
            lane_d  = '0;
        end else if (done) begin
            state_d = StEmpty;
            lane_d  = '0;
        end else if (hs) begin
            lane_d = lane_q + LANE_W'(1);
        end
    end

endmodule

// File: tb/tb_bus_fifo_unpacker.sv
// Bench for bus_fifo_unpacker (WIDTH=8, IN_DEPTH=4): queue-modelled show-ahead FIFO,
// expected beats scoreboarded at push time and checked at each handshake.
module tb_bus_fifo_unpacker;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned LW = 2;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [LW-1:0] lane;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            fifo_empty;
    logic [D*W-1:0]  fifo_rd_data;
    logic            fifo_rd_en;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [LW-1:0]   out_lane;
    logic            out_last;
    logic            busy;
    logic [CW-1:0]   beat_cnt;

    logic [D*W-1:0]  fifo_q[$];
    beat_t           exp_q[$];
    int              n_cmp;
    int              n_err;
    int              cyc;
    logic [CW-1:0]   cnt_model;

    // Per-cycle observations captured just before the active edge.
    logic            s_hs;
    logic            s_rd;
    logic [W-1:0]    s_data;

    always #5 clk = ~clk;

    bus_fifo_unpacker #(
        .WIDTH    (W),
        .IN_DEPTH (D),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_lane     (out_lane),
        .out_last     (out_last),
        .busy         (busy),
        .beat_cnt     (beat_cnt)
    );

    task automatic fifo_push(input logic [D*W-1:0] e);
        beat_t b;
        fifo_q.push_back(e);
        for (int i = 0; i < int'(D); i++) begin
            b.data = e[i*W +: W];
            b.lane = LW'(i);
            b.last = (i == int'(D) - 1);
            exp_q.push_back(b);
        end
        fifo_empty   = 1'b0;
        fifo_rd_data = fifo_q[0];
    endtask

    // One clock: sample, scoreboard any handshake, then let the FIFO model pop.
    task automatic step();
        beat_t got, exp;
        #1;
        s_hs   = out_valid & out_ready;
        s_rd   = fifo_rd_en;
        s_data = out_data;
        if (s_hs) begin
            n_cmp++;
            got = '{data: out_data, lane: out_lane, last: out_last};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got beat %h, expected none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL sb_beat: got %h, expected %h", got, exp);
                end
            end
        end
        if (s_rd && rstn) begin
            n_cmp++;
            if (fifo_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_empty: got rd_en=1, expected 0 with empty FIFO");
            end
        end
        @(posedge clk);
        #1;
        if (!rstn) cnt_model = '0;
        else if (s_hs) cnt_model = cnt_model + 1'b1;
        if (s_rd && rstn && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b1; fifo_empty = 1'b1; fifo_rd_data = '0;
        step(); step();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({out_valid, fifo_rd_en, busy, out_last, out_lane, out_data, beat_cnt} !== '0) begin
                n_err++;
                $display("FAIL reset_idle: got v=%b rd=%b busy=%b last=%b lane=%0d data=%h cnt=%h, expected all 0",
                         out_valid, fifo_rd_en, busy, out_last, out_lane, out_data, beat_cnt);
            end
            step();
        end
    endtask

    task automatic test_single();
        int rd_n = 0, hs_n = 0, rd_cyc = -1, first_hs = -1;
        fifo_push(32'h4433_2211);
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_rd) begin rd_n++; rd_cyc = cyc; end
            if (s_hs) begin hs_n++; if (first_hs < 0) first_hs = cyc; end
        end
        n_cmp++;
        if (rd_n != 1 || hs_n != 4) begin
            n_err++; $display("FAIL single_counts: got rd=%0d beats=%0d, expected 1 and 4", rd_n, hs_n);
        end
        n_cmp++;
        if (first_hs != rd_cyc + 1) begin
            n_err++; $display("FAIL single_latency: got first beat cycle %0d, expected %0d", first_hs, rd_cyc + 1);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || beat_cnt !== 16'd4) begin
            n_err++; $display("FAIL single_end: got v=%b cnt=%0d, expected v=0 cnt=4", out_valid, beat_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int rd_n = 0, hs_n = 0, first = -1, lastc = -1, rd2 = -1, hs44 = -1;
        fifo_push(32'h4433_2211);
        fifo_push(32'h8877_6655);
        for (int i = 0; i < 14; i++) begin
            step();
            if (s_rd) begin rd_n++; if (rd_n == 2) rd2 = cyc; end
            if (s_hs) begin
                hs_n++; lastc = cyc;
                if (first < 0) first = cyc;
                if (s_data == 8'h44) hs44 = cyc;
            end
        end
        n_cmp++;
        if (hs_n != 8 || lastc - first != 7) begin
            n_err++; $display("FAIL b2b_bubble: got %0d beats over %0d cycles, expected 8 over 8", hs_n, lastc - first + 1);
        end
        n_cmp++;
        if (rd_n != 2 || rd2 != hs44) begin
            n_err++; $display("FAIL b2b_reload: got rd#2 cycle %0d, expected %0d (0x44 beat)", rd2, hs44);
        end
        n_cmp++;
        if (beat_cnt !== 16'd12) begin
            n_err++; $display("FAIL b2b_cnt: got %0d, expected 12", beat_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] cnt0;
        fifo_push(32'h4433_2211);
        fifo_push(32'hDDCC_BBAA);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid && out_lane == 2'd1) break;
            step();
        end
        out_ready = 1'b0;
        cnt0 = beat_cnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (!out_valid || out_data !== 8'h22 || out_lane !== 2'd1 || fifo_rd_en || beat_cnt !== cnt0) begin
                n_err++;
                $display("FAIL bp_stall: got v=%b data=%h lane=%0d rd=%b cnt=%0d, expected v=1 data=22 lane=1 rd=0 cnt=%0d",
                         out_valid, out_data, out_lane, fifo_rd_en, beat_cnt, cnt0);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        n_cmp++;
        if (exp_q.size() != 0 || beat_cnt !== cnt0 + 16'd7) begin
            n_err++; $display("FAIL bp_drain: got %0d beats left cnt=%0d, expected 0 left cnt=%0d",
                              exp_q.size(), beat_cnt, cnt0 + 16'd7);
        end
    endtask

    task automatic test_flush();
        logic [CW-1:0] cnt0;
        fifo_push(32'h4433_2211);
        fifo_push(32'h8877_6655);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid && out_lane == 2'd2) break;
            step();
        end
        flush = 1'b1;
        cnt0  = beat_cnt;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            n_err++; $display("FAIL flush_mask: got v=%b rd=%b, expected 0 0", out_valid, fifo_rd_en);
        end
        step();
        flush = 1'b0;
        // Lanes 2 and 3 of the aborted entry are never delivered.
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_lane !== 2'd0 || beat_cnt !== cnt0) begin
            n_err++; $display("FAIL flush_state: got busy=%b lane=%0d cnt=%0d, expected 0 0 %0d",
                              busy, out_lane, beat_cnt, cnt0);
        end
        for (int i = 0; i < 8; i++) step();
        n_cmp++;
        if (exp_q.size() != 0 || beat_cnt !== cnt0 + 16'd4) begin
            n_err++; $display("FAIL flush_next: got %0d left cnt=%0d, expected 0 left cnt=%0d",
                              exp_q.size(), beat_cnt, cnt0 + 16'd4);
        end
    endtask

    task automatic test_reset_mid();
        fifo_push(32'h4433_2211);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid && out_lane == 2'd1) break;
            step();
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, out_lane, out_data, beat_cnt} !== '0) begin
            n_err++; $display("FAIL reset_mid: got v=%b busy=%b lane=%0d data=%h cnt=%h, expected all 0",
                              out_valid, busy, out_lane, out_data, beat_cnt);
        end
        exp_q.delete();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (cnt_model != 16'hFFFF && guard < 70000) begin
            if (fifo_q.size() < 2) fifo_push({$urandom} & 32'hFFFF_FFFF);
            step();
            guard++;
        end
        #1;
        n_cmp++;
        if (beat_cnt !== 16'hFFFF || !out_valid) begin
            n_err++; $display("FAIL wrap_pre: got cnt=%h v=%b, expected FFFF 1", beat_cnt, out_valid);
        end
        step();
        n_cmp++;
        if (beat_cnt !== 16'h0000) begin
            n_err++; $display("FAIL wrap_post: got cnt=%h, expected 0000", beat_cnt);
        end
        for (int i = 0; i < 12; i++) step();
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL wrap_drain: got %0d left v=%b, expected 0 left v=0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; cnt_model = '0;
        s_hs = 1'b0; s_rd = 1'b0; s_data = '0;
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b1; fifo_empty = 1'b1; fifo_rd_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
